// File: rtl/regwrite_tracer.sv
// Register-file write tracer: captures watched CPU register writes into a trace FIFO.
// Optional per-entry cycle stamps are built when REGWRITE_TRACER_TIMESTAMP_EN is defined.
module regwrite_tracer #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 32,
    parameter int CHANGE_ONLY = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [NUM_REGS-1:0]     watch_mask,
    input  logic                    clear,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [ADDR_W-1:0]       trace_addr,
    output logic [DATA_W-1:0]       trace_data,
    output logic [TS_W-1:0]         trace_stamp,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              addr_hit;
    logic              watched;
    logic [DATA_W-1:0] old_val;
    logic              shadow_wr;
    logic              changed;
    logic              push;
    logic              pop;
    logic              full;
    logic              do_push;
    logic              drop;

    // Register 0 and out-of-range addresses never match, so they are neither traced nor shadowed.
    always_comb begin
        addr_hit = 1'b0;
        watched  = 1'b0;
        old_val  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                addr_hit = 1'b1;
                watched  = watch_mask[i];
                old_val  = shadow[i];
            end
        end
    end

    assign shadow_wr = wr_en && addr_hit;
    assign changed   = (CHANGE_ONLY == 0) || (wr_data != old_val);
    assign push      = shadow_wr && watched && changed;
    assign pop       = trace_valid && trace_ready;
    assign full      = (level == LVL_W'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || pop);
    assign drop      = push && full && !pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (shadow_wr && wr_addr == ADDR_W'(i)) shadow[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the head outputs are masked to zero while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= wr_addr;
            data_mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clear ? 16'd1 :
                          (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    assign trace_valid = (level != '0);
    assign trace_addr  = trace_valid ? addr_mem[rd_ptr] : '0;
    assign trace_data  = trace_valid ? data_mem[rd_ptr] : '0;

`ifdef REGWRITE_TRACER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_count;
    logic [TS_W-1:0] stamp_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) ts_count <= '0;
        else        ts_count <= ts_count + TS_W'(1);
    end

    always_ff @(posedge clock) begin
        if (do_push) stamp_mem[wr_ptr] <= ts_count;
    end

    assign trace_stamp = trace_valid ? stamp_mem[rd_ptr] : '0;
`else
    assign trace_stamp = '0;
`endif

endmodule

// File: doc/regwrite_tracer.md
REGWRITE_TRACER -- requirements
Module: regwrite_tracer

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width.
REQ-002 SHALL provide parameter NUM_REGS, default 32, number of architectural registers observed.
REQ-003 SHALL provide parameter ADDR_W, default 5, register address width; NUM_REGS <= 2**ADDR_W.
REQ-004 SHALL provide parameter DEPTH, default 16, trace FIFO entries; power of two, >= 2.
REQ-005 SHALL provide parameter TS_W, default 32, timestamp width.
REQ-006 SHALL provide parameter CHANGE_ONLY, default 0; 1 = record only value-changing writes.
REQ-007 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port wr_en  input  1  CPU register-file write strobe.
REQ-010 SHALL have port wr_addr  input  ADDR_W  destination register of write.
REQ-011 SHALL have port wr_data  input  DATA_W  value written.
REQ-012 SHALL have port watch_mask  input  NUM_REGS  bit i = 1 enables tracing of register i.
REQ-013 SHALL have port clear  input  1  clears overflow and drop_count.
REQ-014 SHALL have port trace_valid  output  1  head entry present.
REQ-015 SHALL have port trace_ready  input  1  consumer accepts head entry.
REQ-016 SHALL have port trace_addr  output  ADDR_W  head entry register number.
REQ-017 SHALL have port trace_data  output  DATA_W  head entry value.
REQ-018 SHALL have port trace_stamp  output  TS_W  head entry cycle stamp.
REQ-019 SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-020 SHALL have port overflow  output  1  sticky, set when an entry is dropped.
REQ-021 SHALL have port drop_count  output  16  dropped-entry count, saturating.

Function
REQ-022 A write SHALL qualify when wr_en=1, wr_addr!=0, wr_addr<NUM_REGS, watch_mask[wr_addr]=1, and (CHANGE_ONLY=0 or wr_data != shadow[wr_addr]).
REQ-023 Shadow copy shadow[wr_addr] SHALL update on every wr_en with wr_addr in 1..NUM_REGS-1, regardless of watch_mask or FIFO state.
REQ-024 Register 0 writes SHALL never be traced or shadowed.
REQ-025 Free-running counter SHALL start at 0 after reset, increment every cycle, wrap 2**TS_W-1 -> 0; entry stamp = counter value in capture cycle.
REQ-026 A qualifying write SHALL appear at FIFO head (trace_valid=1) no earlier than the cycle after capture; latency into empty FIFO exactly 1 cycle.
REQ-027 Entry SHALL pop on cycle with trace_valid=1 and trace_ready=1; entries leave in capture order.
REQ-028 trace_addr/data/stamp SHALL hold stable while trace_valid=1 and trace_ready=0.
REQ-029 Push and pop in same cycle SHALL both occur, level unchanged, including when full.
REQ-030 Push when full without pop SHALL drop the new entry, set overflow, increment drop_count (saturate at 0xFFFF); FIFO contents unchanged.
REQ-031 clear SHALL zero overflow and drop_count next cycle; a drop in the same cycle as clear SHALL win: overflow=1, drop_count=1.
REQ-032 level SHALL equal entries held, 0..DEPTH; trace_valid = (level!=0).
REQ-033 Pointers SHALL wrap modulo DEPTH without losing or duplicating entries.

Reset
REQ-034 With reset=0 at a clock edge: level=0, trace_valid=0, overflow=0, drop_count=0, counter=0, all shadow registers=0, trace_addr/data/stamp=0.
REQ-035 Reset mid-operation SHALL discard all FIFO entries; writes in the reset cycle SHALL NOT be captured.

Configuration
REQ-036 Macro REGWRITE_TRACER_TIMESTAMP_EN defined: counter and per-entry stamp storage built, trace_stamp per REQ-025.
REQ-037 Macro undefined: no counter or stamp storage; trace_stamp SHALL be constant 0; all other behaviour identical.

Verification
REQ-038 Defaults, mask all-ones, write r5=0x0000_00AA at cycle 10, ready=1 -> valid at cycle 11, addr=5, data=0xAA, stamp=10 (macro on).
REQ-039 Write r0=0x1234 and r7 with watch_mask[7]=0 -> trace_valid stays 0, level 0.
REQ-040 ready=0, 17 qualifying writes, DEPTH=16 -> level=16, overflow=1, drop_count=1; drained data equals first 16 writes in order.
REQ-041 Full FIFO, ready=1 with simultaneous write -> level stays 16, no drop, new entry emerges last.
REQ-042 CHANGE_ONLY=1: write r3=0x55 twice, then r3=0x56 -> exactly two entries (0x55, 0x56).
REQ-043 Assert reset=0 with level=9 for one cycle -> next cycle level=0, trace_valid=0, drop_count=0.
